// File: rtl/gru_ctrl_pkg.sv
// Shared types and default constants for the GRU sequence controller.
package gru_ctrl_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_FRACT_WIDTH = 5;
    localparam int DEF_CELL_LAT    = 2;
    localparam int LAT_W           = 4;   // holds CELL_LAT-1 for CELL_LAT up to 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        CAPT = 2'd2,
        OUT  = 2'd3
    } gru_state_t;

endpackage

// File: rtl/gru_lat_timer.sv
// Loadable down-counter that times the settle window of the external GRU cell.
module gru_lat_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    // Clear has priority, then load, then a decrement that stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/gru_seq_ctrl.sv
// Step controller for an external combinational GRU cell: accepts one sample,
// waits for the cell to settle, captures h_out and offers it downstream.
module gru_seq_ctrl
    import gru_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int FRACT_WIDTH = DEF_FRACT_WIDTH,
    parameter int CELL_LAT    = DEF_CELL_LAT,
    parameter int CNT_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         x_valid,
    output logic                         x_ready,
    input  logic signed [DATA_WIDTH-1:0] x_data,
    input  logic                         x_last,
    output logic signed [DATA_WIDTH-1:0] cell_x,
    output logic signed [DATA_WIDTH-1:0] cell_h_in,
    input  logic signed [DATA_WIDTH-1:0] cell_h_out,
    output logic                         h_valid,
    input  logic                         h_ready,
    output logic signed [DATA_WIDTH-1:0] h_data,
    output logic                         h_last,
    output logic [CNT_W-1:0]             step_cnt,
    output logic                         busy
);

    // Fixed-point format is only carried for the cell; sanity-check it here.
    if (CELL_LAT < 1 || CELL_LAT > 15) begin : g_bad_lat
        $error("gru_seq_ctrl: CELL_LAT must be 1..15");
    end
    if (FRACT_WIDTH < 0 || FRACT_WIDTH >= DATA_WIDTH) begin : g_bad_fract
        $error("gru_seq_ctrl: FRACT_WIDTH must be below DATA_WIDTH");
    end

    gru_state_t                   state;
    logic signed [DATA_WIDTH-1:0] x_reg;
    logic signed [DATA_WIDTH-1:0] h_reg;
    logic                         last_reg;
    logic                         lat_zero;
    logic                         lat_load;
    logic                         lat_dec;

    // Timer is loaded on the accepting cycle and counts only while in WAIT.
    always_comb begin
        lat_load = (state == IDLE) && x_valid && !clr;
        lat_dec  = (state == WAIT);
    end

    gru_lat_timer #(
        .W (LAT_W)
    ) u_lat_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .load     (lat_load),
        .dec      (lat_dec),
        .load_val (LAT_W'(CELL_LAT - 1)),
        .zero     (lat_zero)
    );

    // Step sequencing FSM with registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x_reg    <= '0;
            h_reg    <= '0;
            last_reg <= 1'b0;
            step_cnt <= '0;
            x_ready  <= 1'b1;
            h_valid  <= 1'b0;
            busy     <= 1'b0;
        end else if (clr) begin
            state    <= IDLE;
            x_reg    <= '0;
            h_reg    <= '0;
            last_reg <= 1'b0;
            step_cnt <= '0;
            x_ready  <= 1'b1;
            h_valid  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (x_valid) begin
                        x_reg    <= x_data;
                        last_reg <= x_last;
                        x_ready  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_zero) begin
                        state <= CAPT;
                    end
                end
                CAPT: begin
                    h_reg <= cell_h_out;
                    if (step_cnt != '1) begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                    h_valid <= 1'b1;
                    state   <= OUT;
                end
                OUT: begin
                    if (h_ready) begin
                        if (last_reg) begin
                            h_reg    <= '0;
                            step_cnt <= '0;
                        end
                        h_valid <= 1'b0;
                        x_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cell_x    = x_reg;
    assign cell_h_in = h_reg;
    assign h_data    = h_reg;
    assign h_last    = last_reg;

endmodule

// File: tb/tb_gru_seq_ctrl.sv
// Directed bench for gru_seq_ctrl with a wrapping-add cell stub (h_out = X + h_in).
// A second instance with a 2-bit step counter shares the stimulus.
module tb_gru_seq_ctrl;

    logic              clk;
    logic              rst_n;
    logic              clr;
    logic              x_valid;
    logic signed [7:0] x_data;
    logic              x_last;
    logic              h_ready;

    logic              x_ready,  x_ready2;
    logic signed [7:0] cell_x,   cell_x2;
    logic signed [7:0] cell_hin, cell_hin2;
    logic signed [7:0] cell_hout, cell_hout2;
    logic              h_valid,  h_valid2;
    logic signed [7:0] h_data,   h_data2;
    logic              h_last,   h_last2;
    logic [7:0]        step_cnt;
    logic [1:0]        step_cnt2;
    logic              busy,     busy2;

    int tests_run = 0;
    int tests_failed = 0;

    assign cell_hout  = cell_x + cell_hin;
    assign cell_hout2 = cell_x2 + cell_hin2;

    gru_seq_ctrl #(
        .DATA_WIDTH  (8),
        .FRACT_WIDTH (5),
        .CELL_LAT    (2),
        .CNT_W       (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .x_valid    (x_valid),
        .x_ready    (x_ready),
        .x_data     (x_data),
        .x_last     (x_last),
        .cell_x     (cell_x),
        .cell_h_in  (cell_hin),
        .cell_h_out (cell_hout),
        .h_valid    (h_valid),
        .h_ready    (h_ready),
        .h_data     (h_data),
        .h_last     (h_last),
        .step_cnt   (step_cnt),
        .busy       (busy)
    );

    gru_seq_ctrl #(
        .DATA_WIDTH  (8),
        .FRACT_WIDTH (5),
        .CELL_LAT    (2),
        .CNT_W       (2)
    ) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .x_valid    (x_valid),
        .x_ready    (x_ready2),
        .x_data     (x_data),
        .x_last     (x_last),
        .cell_x     (cell_x2),
        .cell_h_in  (cell_hin2),
        .cell_h_out (cell_hout2),
        .h_valid    (h_valid2),
        .h_ready    (h_ready),
        .h_data     (h_data2),
        .h_last     (h_last2),
        .step_cnt   (step_cnt2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one sample and wait for h_valid; checks the 4-cycle latency.
    task automatic send(input logic [7:0] x, input logic lst);
        int n;
        chk("x_ready_before", 32'(x_ready), 32'd1);
        x_valid = 1'b1;
        x_data  = x;
        x_last  = lst;
        tick();
        x_valid = 1'b0;
        chk("x_ready_wait", 32'(x_ready), 32'd0);
        chk("cell_x", 32'($unsigned(cell_x)), 32'(x));
        n = 0;
        while (!h_valid && n < 20) begin
            tick();
            n++;
        end
        chk("latency", 32'(n), 32'd3);
    endtask

    // Check the offered result, then complete the handshake (h_ready assumed 1).
    task automatic take(input logic [7:0] exp_h, input logic exp_last,
                        input int exp_cnt, input int exp_cnt2);
        chk("h_data", 32'($unsigned(h_data)), 32'(exp_h));
        chk("h_last", 32'(h_last), 32'(exp_last));
        tick();
        chk("h_valid_after", 32'(h_valid), 32'd0);
        chk("step_cnt", 32'(step_cnt), 32'(exp_cnt));
        chk("step_cnt_sat", 32'(step_cnt2), 32'(exp_cnt2));
    endtask

    initial begin
        rst_n   = 1'b0;
        clr     = 1'b0;
        x_valid = 1'b0;
        x_data  = '0;
        x_last  = 1'b0;
        h_ready = 1'b1;

        // Reset held for three cycles
        repeat (3) tick();
        chk("rst_x_ready", 32'(x_ready), 32'd1);
        chk("rst_h_valid", 32'(h_valid), 32'd0);
        chk("rst_step_cnt", 32'(step_cnt), 32'd0);
        chk("rst_cell_h_in", 32'($unsigned(cell_hin)), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Three-step sequence: 0x20, 0x10, 0x08 accumulating
        send(8'h20, 1'b0);
        chk("busy_out", 32'(busy), 32'd1);
        take(8'h20, 1'b0, 1, 1);
        chk("h_persist", 32'($unsigned(cell_hin)), 32'h20);
        send(8'h10, 1'b0);
        take(8'h30, 1'b0, 2, 2);
        send(8'h08, 1'b1);
        take(8'h38, 1'b1, 0, 0);
        chk("seq_h_reg_clr", 32'($unsigned(cell_hin)), 32'd0);

        // Backpressure for five cycles
        h_ready = 1'b0;
        send(8'h05, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_h_valid", 32'(h_valid), 32'd1);
            chk("bp_h_data", 32'($unsigned(h_data)), 32'h05);
            chk("bp_x_ready", 32'(x_ready), 32'd0);
        end
        h_ready = 1'b1;
        take(8'h05, 1'b1, 0, 0);
        chk("bp_idle", 32'(x_ready), 32'd1);
        tick();
        chk("bp_single", 32'(h_valid), 32'd0);

        // clr during WAIT of step 2 beats a simultaneous sample offer
        send(8'h10, 1'b0);
        take(8'h10, 1'b0, 1, 1);
        x_valid = 1'b1;
        x_data  = 8'h20;
        x_last  = 1'b0;
        tick();
        x_valid = 1'b0;
        chk("clr_in_wait", 32'(busy), 32'd1);
        clr     = 1'b1;
        x_valid = 1'b1;
        x_data  = 8'h7F;
        tick();
        clr     = 1'b0;
        x_valid = 1'b0;
        chk("clr_idle", 32'(x_ready), 32'd1);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_h_valid", 32'(h_valid), 32'd0);
        chk("clr_step_cnt", 32'(step_cnt), 32'd0);
        chk("clr_cell_x", 32'($unsigned(cell_x)), 32'd0);
        chk("clr_cell_h_in", 32'($unsigned(cell_hin)), 32'd0);
        send(8'h04, 1'b1);
        take(8'h04, 1'b1, 0, 0);

        // Reset asserted mid-OUT drops h_valid without waiting for a clock
        h_ready = 1'b0;
        send(8'h11, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_h_valid", 32'(h_valid), 32'd0);
        chk("arst_x_ready", 32'(x_ready), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_h_data", 32'($unsigned(h_data)), 32'd0);
        chk("arst_cell_x", 32'($unsigned(cell_x)), 32'd0);
        chk("arst_step_cnt", 32'(step_cnt), 32'd0);
        chk("arst_h_last", 32'(h_last), 32'd0);
        tick();
        rst_n   = 1'b1;
        h_ready = 1'b1;
        tick();
        chk("arst_resume", 32'(h_valid), 32'd0);

        // Counter saturation on the 2-bit instance
        send(8'h01, 1'b0);
        take(8'h01, 1'b0, 1, 1);
        send(8'h01, 1'b0);
        take(8'h02, 1'b0, 2, 2);
        send(8'h01, 1'b0);
        take(8'h03, 1'b0, 3, 3);
        send(8'h01, 1'b0);
        take(8'h04, 1'b0, 4, 3);
        send(8'h01, 1'b0);
        take(8'h05, 1'b0, 5, 3);
        chk("sat_h_data2", 32'($unsigned(h_data2)), 32'h05);

        // Clear in IDLE with a sample offered: nothing accepted
        clr     = 1'b1;
        x_valid = 1'b1;
        x_data  = 8'h33;
        tick();
        clr     = 1'b0;
        x_valid = 1'b0;
        chk("clr_idle_busy", 32'(busy), 32'd0);
        chk("clr_idle_cnt", 32'(step_cnt2), 32'd0);
        tick();
        chk("clr_idle_noacc", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got stalled expected finish");
        $fatal(1, "timeout");
    end

endmodule
